// File: rtl/me_search_ctrl.sv
// Steps the me_integer engine around a 16x16 block, moving STEP pixels toward the best neighbour.
// Adds two cycles per iteration beyond engine latency; one request in flight, and start is ignored while busy.
module me_search_ctrl #(
   parameter int STEP     = 4,
   parameter int MAX_ITER = 8,
   parameter int POS_MIN  = 4,
   parameter int POS_MAX  = 44
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [11:0] start_pos,
   output logic        busy,
   output logic        done,
   output logic [11:0] final_pos,
   output logic [15:0] final_sad,
   output logic [3:0]  iter_cnt,
   output logic [1:0]  status,
   output logic        me_req,
   output logic [11:0] me_init_pos,
   input  logic [15:0] me_min_sad,
   input  logic [3:0]  me_min_diff,
   input  logic        me_ack
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EVAL,
      DONE
   } state_t;

   localparam logic [1:0] ST_CONV  = 2'd0;
   localparam logic [1:0] ST_NOIMP = 2'd1;
   localparam logic [1:0] ST_BOUND = 2'd2;
   localparam logic [1:0] ST_LIMIT = 2'd3;

   localparam logic signed [6:0] STEP7   = 7'(STEP);
   localparam logic signed [6:0] MIN7    = 7'(POS_MIN);
   localparam logic signed [6:0] MAX7    = 7'(POS_MAX);
   localparam logic [5:0]        MIN6    = 6'(POS_MIN);
   localparam logic [5:0]        MAX6    = 6'(POS_MAX);
   localparam logic [3:0]        MAX_IT4 = 4'(MAX_ITER);

   state_t state, state_nxt;

   logic [11:0] cur_pos;
   logic [15:0] best_sad;
   logic [3:0]  iter;
   logic [15:0] sad_cap;
   logic [3:0]  diff_cap;

   logic              start_ok;
   logic              diff_bad;
   logic              no_gain;
   logic              next_ok;
   logic signed [6:0] off_x, off_y;
   logic signed [6:0] nx7, ny7;
   logic [11:0]       next_pos;

   logic        stop;
   logic [1:0]  stop_status;
   logic [11:0] stop_pos;
   logic [15:0] stop_sad;
   logic [3:0]  stop_iter;

   function automatic logic signed [6:0] axis_off(input logic [1:0] d);
      case (d)
         2'b01:   axis_off = STEP7;
         2'b11:   axis_off = -STEP7;
         default: axis_off = '0;
      endcase
   endfunction

   assign start_ok = (start_pos[5:0]  >= MIN6) && (start_pos[5:0]  <= MAX6) &&
                     (start_pos[11:6] >= MIN6) && (start_pos[11:6] <= MAX6);

   assign diff_bad = (diff_cap[1:0] == 2'b10) || (diff_cap[3:2] == 2'b10);
   assign no_gain  = (iter > 4'd1) && (sad_cap >= best_sad);

   // 7-bit signed so a step below zero is seen as out of range, not wrapped
   assign off_x    = axis_off(diff_cap[1:0]);
   assign off_y    = axis_off(diff_cap[3:2]);
   assign nx7      = $signed({1'b0, cur_pos[5:0]})  + off_x;
   assign ny7      = $signed({1'b0, cur_pos[11:6]}) + off_y;
   assign next_ok  = (nx7 >= MIN7) && (nx7 <= MAX7) && (ny7 >= MIN7) && (ny7 <= MAX7);
   assign next_pos = {ny7[5:0], nx7[5:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      stop        = 1'b0;
      stop_status = ST_CONV;
      stop_pos    = cur_pos;
      stop_sad    = best_sad;
      stop_iter   = iter;
      case (state)
         IDLE: begin
            if (start) begin
               if (start_ok) begin
                  state_nxt = ISSUE;
               end else begin
                  state_nxt   = DONE;
                  stop        = 1'b1;
                  stop_status = ST_BOUND;
                  stop_pos    = start_pos;
                  stop_sad    = 16'hFFFF;
                  stop_iter   = 4'd0;
               end
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (me_ack) begin
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            state_nxt = DONE;
            stop      = 1'b1;
            if (diff_bad) begin
               stop_status = ST_LIMIT;
            end else if (no_gain) begin
               stop_status = ST_NOIMP;
            end else if (diff_cap == 4'd0) begin
               stop_status = ST_CONV;
               stop_sad    = sad_cap;
            end else if (!next_ok) begin
               stop_status = ST_BOUND;
               stop_sad    = sad_cap;
            end else if (iter == MAX_IT4) begin
               stop_status = ST_LIMIT;
               stop_pos    = next_pos;
               stop_sad    = sad_cap;
            end else begin
               stop      = 1'b0;
               state_nxt = ISSUE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         me_req      <= 1'b0;
         me_init_pos <= 12'd0;
         final_pos   <= 12'd0;
         final_sad   <= 16'hFFFF;
         iter_cnt    <= 4'd0;
         status      <= ST_CONV;
         cur_pos     <= 12'd0;
         best_sad    <= 16'hFFFF;
         iter        <= 4'd0;
         sad_cap     <= 16'd0;
         diff_cap    <= 4'd0;
      end else begin
         busy   <= (state_nxt != IDLE);
         done   <= (state_nxt == DONE);
         me_req <= (state_nxt == ISSUE);

         case (state)
            IDLE: begin
               if (start) begin
                  cur_pos  <= start_pos;
                  best_sad <= 16'hFFFF;
                  iter     <= 4'd0;
               end
            end
            ISSUE: iter <= iter + 4'd1;
            WAIT: begin
               if (me_ack) begin
                  sad_cap  <= me_min_sad;
                  diff_cap <= me_min_diff;
               end
            end
            EVAL: begin
               if (!diff_bad && !no_gain) begin
                  best_sad <= sad_cap;
               end
               if (state_nxt == ISSUE) begin
                  cur_pos <= next_pos;
               end
            end
            default: ;
         endcase

         // engine sees the centre being written into cur_pos this same edge
         if (state_nxt == ISSUE) begin
            me_init_pos <= (state == IDLE) ? start_pos : next_pos;
         end

         if (stop) begin
            final_pos <= stop_pos;
            final_sad <= stop_sad;
            iter_cnt  <= stop_iter;
            status    <= stop_status;
         end
      end
   end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl: a scripted engine answers each me_req while a
// position/SAD-level model predicts the request centres and final results.
`timescale 1ns/1ps
module tb_me_search_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] start_pos = 12'd0;
   logic        busy, done;
   logic [11:0] final_pos;
   logic [15:0] final_sad;
   logic [3:0]  iter_cnt;
   logic [1:0]  status;
   logic        me_req;
   logic [11:0] me_init_pos;
   logic [15:0] me_min_sad = 16'd0;
   logic [3:0]  me_min_diff = 4'd0;
   logic        me_ack = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   me_search_ctrl #(.STEP(4), .MAX_ITER(8), .POS_MIN(4), .POS_MAX(44)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .start_pos   (start_pos),
      .busy        (busy),
      .done        (done),
      .final_pos   (final_pos),
      .final_sad   (final_sad),
      .iter_cnt    (iter_cnt),
      .status      (status),
      .me_req      (me_req),
      .me_init_pos (me_init_pos),
      .me_min_sad  (me_min_sad),
      .me_min_diff (me_min_diff),
      .me_ack      (me_ack)
   );

   logic [15:0] rep_sad  [16];
   logic [3:0]  rep_diff [16];
   int          rsp_idx = 0;

   logic [11:0] exp_q [$];
   logic        exp_valid = 1'b0;
   logic [11:0] exp_fpos = 12'd0;
   logic [15:0] exp_fsad = 16'd0;
   logic [3:0]  exp_iter = 4'd0;
   logic [1:0]  exp_status = 2'd0;
   int          exp_nreq = 0;

   int   cyc = 0;
   int   last_ack_cyc = -100;
   int   done_cnt = 0;
   int   job_req = 0;
   logic done_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [11:0] mkpos(input int y, input int x);
      logic [5:0] yy, xx;
      yy = 6'(y);
      xx = 6'(x);
      return {yy, xx};
   endfunction

   function automatic int dec(input logic [1:0] d);
      case (d)
         2'b01:   return 1;
         2'b11:   return -1;
         2'b00:   return 0;
         default: return 99;
      endcase
   endfunction

   task automatic set_exp(input logic [11:0] p, input int s, input int it, input int st);
      exp_fpos   = p;
      exp_fsad   = 16'(s);
      exp_iter   = 4'(it);
      exp_status = 2'(st);
   endtask

   function automatic bit out_rng(input int v);
      return (v < 4) || (v > 44);
   endfunction

   // Walks the search with plain integer coordinates and the scripted replies.
   task automatic model(input logic [11:0] sp);
      int x, y, nx, ny, dx, dy, it, best, s;
      exp_q.delete();
      x = int'(sp[5:0]);
      y = int'(sp[11:6]);
      best = 'hFFFF;
      it = 0;
      exp_nreq = 0;
      if (out_rng(x) || out_rng(y)) begin
         set_exp(sp, 'hFFFF, 0, 2);
         return;
      end
      forever begin
         it++;
         exp_q.push_back(mkpos(y, x));
         exp_nreq = it;
         s  = int'(rep_sad[it-1]);
         dx = dec(rep_diff[it-1][1:0]);
         dy = dec(rep_diff[it-1][3:2]);
         if (dx == 99 || dy == 99) begin set_exp(mkpos(y, x), best, it, 3); return; end
         if (it > 1 && s >= best)  begin set_exp(mkpos(y, x), best, it, 1); return; end
         best = s;
         if (dx == 0 && dy == 0)   begin set_exp(mkpos(y, x), best, it, 0); return; end
         nx = x + 4 * dx;
         ny = y + 4 * dy;
         if (out_rng(nx) || out_rng(ny)) begin set_exp(mkpos(y, x), best, it, 2); return; end
         if (it == 8) begin set_exp(mkpos(ny, nx), best, it, 3); return; end
         x = nx;
         y = ny;
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scripted engine: answers each request three cycles later with the next reply.
   initial begin : engine
      int k;
      forever begin
         @(negedge clk);
         if (me_req) begin
            k = rsp_idx % 16;
            rsp_idx++;
            repeat (3) @(posedge clk);
            #1;
            me_ack      = 1'b1;
            me_min_sad  = rep_sad[k];
            me_min_diff = rep_diff[k];
            @(posedge clk);
            #1;
            me_ack      = 1'b0;
            me_min_sad  = 16'd0;
            me_min_diff = 4'd0;
         end
      end
   end

   always @(negedge clk) begin
      if (me_ack) last_ack_cyc = cyc;
      if (me_req) begin
         if (exp_q.size() == 0) fail("req_unexpected");
         else chk("me_init_pos", 32'(me_init_pos), 32'(exp_q.pop_front()));
         if (job_req > 0) chk("ack_to_req_cycles", 32'(cyc - last_ack_cyc), 32'd2);
         job_req++;
      end
      if (done) begin
         done_cnt++;
         if (!exp_valid) begin
            fail("done_unexpected");
         end else begin
            chk("final_pos", 32'(final_pos), 32'(exp_fpos));
            chk("final_sad", 32'(final_sad), 32'(exp_fsad));
            chk("iter_cnt",  32'(iter_cnt),  32'(exp_iter));
            chk("status",    32'(status),    32'(exp_status));
            chk("busy_at_done", 32'(busy), 32'd1);
            if (exp_nreq > 0) chk("ack_to_done_cycles", 32'(cyc - last_ack_cyc), 32'd2);
         end
         exp_valid = 1'b0;
      end
      if (done_prev) chk("busy_fall", 32'(busy), 32'd0);
      done_prev = done;
   end

   task automatic set_rep(input int i, input int s, input logic [3:0] d);
      rep_sad[i]  = 16'(s);
      rep_diff[i] = d;
   endtask

   task automatic run_job(input logic [11:0] sp, input bit poke);
      int d0;
      model(sp);
      rsp_idx   = 0;
      job_req   = 0;
      exp_valid = 1'b1;
      d0        = done_cnt;
      @(posedge clk); #1;
      start     = 1'b1;
      start_pos = sp;
      @(posedge clk); #1;
      start     = 1'b0;
      start_pos = 12'd0;
      @(negedge clk);
      chk("req_after_start", 32'(me_req), 32'(exp_nreq > 0));
      chk("busy_after_start", 32'(busy), 32'd1);
      if (poke) begin
         @(posedge clk); #1;
         start     = 1'b1;
         start_pos = 12'h2C8;
         @(posedge clk); #1;
         start     = 1'b0;
         start_pos = 12'd0;
      end
      for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) fail("done_timeout");
      chk("req_count", 32'(job_req), 32'(exp_nreq));
      repeat (3) @(negedge clk);
   endtask

   task automatic lit(input logic [11:0] p, input logic [15:0] s, input logic [3:0] it,
                      input logic [1:0] st);
      chk("lit_final_pos", 32'(final_pos), 32'(p));
      chk("lit_final_sad", 32'(final_sad), 32'(s));
      chk("lit_iter_cnt",  32'(iter_cnt),  32'(it));
      chk("lit_status",    32'(status),    32'(st));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"},        32'(busy),        32'd0);
      chk({tag, "_done"},        32'(done),        32'd0);
      chk({tag, "_me_req"},      32'(me_req),      32'd0);
      chk({tag, "_me_init_pos"}, 32'(me_init_pos), 32'd0);
      chk({tag, "_final_pos"},   32'(final_pos),   32'd0);
      chk({tag, "_final_sad"},   32'(final_sad),   32'hFFFF);
      chk({tag, "_iter_cnt"},    32'(iter_cnt),    32'd0);
      chk({tag, "_status"},      32'(status),      32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int d0;
      for (int i = 0; i < 16; i++) set_rep(i, 0, 4'd0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // converge at {20,20}
      set_rep(0, 500, 4'b0000);
      run_job(12'h514, 1'b0);
      lit(12'h514, 16'd500, 4'd1, 2'd0);

      // descent {20,20}->{20,24}->{16,24}, with an ignored start while busy
      set_rep(0, 900, 4'b0001);
      set_rep(1, 600, 4'b1100);
      set_rep(2, 400, 4'b0000);
      run_job(12'h514, 1'b1);
      lit(12'h418, 16'd400, 4'd3, 2'd0);

      // no improvement
      set_rep(0, 300, 4'b0001);
      set_rep(1, 350, 4'b0001);
      run_job(12'h514, 1'b0);
      lit(12'h518, 16'd300, 4'd2, 2'd1);

      // step past the top edge from {44,40}
      set_rep(0, 100, 4'b0100);
      run_job(12'hB28, 1'b0);
      lit(12'hB28, 16'd100, 4'd1, 2'd2);

      // step below the low edge from {4,4}
      set_rep(0, 700, 4'b0011);
      run_job(12'h104, 1'b0);
      lit(12'h104, 16'd700, 4'd1, 2'd2);

      // illegal start {2,30}
      run_job(12'h09E, 1'b0);
      lit(12'h09E, 16'hFFFF, 4'd0, 2'd2);

      // iteration limit walking +x from {4,4}
      for (int i = 0; i < 8; i++) set_rep(i, 1000 - 50 * i, 4'b0001);
      run_job(12'h104, 1'b0);
      lit(12'h124, 16'd650, 4'd8, 2'd3);

      // illegal diff field
      set_rep(0, 200, 4'b1000);
      run_job(12'h514, 1'b0);
      lit(12'h514, 16'hFFFF, 4'd1, 2'd3);

      // reset while waiting for the engine; the late ack must be ignored
      set_rep(0, 50, 4'b0000);
      exp_q.delete();
      exp_q.push_back(12'h514);
      exp_valid = 1'b0;
      rsp_idx   = 0;
      job_req   = 0;
      d0        = done_cnt;
      @(posedge clk); #1;
      start     = 1'b1;
      start_pos = 12'h514;
      @(posedge clk); #1;
      start     = 1'b0;
      start_pos = 12'd0;
      for (int i = 0; i < 20 && job_req == 0; i++) @(negedge clk);
      chk("abort_req_seen", 32'(job_req), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("abort");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      check_reset("post_abort");

      // recovery after the abort
      set_rep(0, 123, 4'b0000);
      run_job(12'h30C, 1'b0);
      lit(12'h30C, 16'd123, 4'd1, 2'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
